// File: rtl/sync_payload_capture_if.sv
// sync_payload_capture_if: serial input, detect pulse and valid/ready payload output of the capture block
interface sync_payload_capture_if #(
    parameter int PAYLOAD_W = 16,
    parameter int CNT_W = 8
);
    logic x_i;
    logic det_i;
    logic ready_i;
    logic [PAYLOAD_W-1:0] payload_o;
    logic valid_o;
    logic busy_o;
    logic [CNT_W-1:0] frame_cnt_o;
    logic overrun_o;
    modport master (
        output x_i, det_i, ready_i,
        input payload_o, valid_o, busy_o, frame_cnt_o, overrun_o
    );
    modport slave (
        input x_i, det_i, ready_i,
        output payload_o, valid_o, busy_o, frame_cnt_o, overrun_o
    );
endinterface

// File: rtl/sync_payload_capture.sv
// sync_payload_capture: deserialises the payload after each sync detect into a single-entry valid/ready register
module sync_payload_capture #(
    parameter int PAYLOAD_W = 16,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic reset,
    sync_payload_capture_if.slave bus
);
    localparam int IDX_W = $clog2(PAYLOAD_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_W - 1);
    typedef enum logic {IDLE, CAPTURE} state_t;
    state_t state, state_n;
    logic [PAYLOAD_W-1:0] shreg, shreg_n, payload;
    logic [IDX_W-1:0] idx, idx_n;
    logic [CNT_W-1:0] frame_cnt;
    logic valid, overrun, done, load, take;
    // Detect starts a frame with the current bit already captured; the frame ends on the bit at LAST_IDX
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        idx_n = idx;
        done = 1'b0;
        if (state == IDLE) begin
            if (bus.det_i) begin
                state_n = CAPTURE;
                shreg_n = {{(PAYLOAD_W-1){1'b0}}, bus.x_i};
                idx_n = IDX_W'(1);
            end
        end else begin
            shreg_n = {shreg[PAYLOAD_W-2:0], bus.x_i};
            idx_n = idx + 1'b1;
            if (idx == LAST_IDX) begin
                done = 1'b1;
                state_n = IDLE;
                idx_n = '0;
            end
        end
    end
    assign take = valid & bus.ready_i;
    assign load = done & (~valid | bus.ready_i);
    // State, shifter and output register; a completed frame is dropped only when the register is stuck full
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            idx <= '0;
            payload <= '0;
            valid <= 1'b0;
            frame_cnt <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            idx <= idx_n;
            if (load) payload <= shreg_n;
            valid <= load | (valid & ~take);
            frame_cnt <= frame_cnt + CNT_W'(load);
            overrun <= overrun | (done & valid & ~bus.ready_i);
        end
    end
    assign bus.payload_o = payload;
    assign bus.valid_o = valid;
    assign bus.busy_o = (state == CAPTURE);
    assign bus.frame_cnt_o = frame_cnt;
    assign bus.overrun_o = overrun;
endmodule

// File: tb/tb_sync_payload_capture.sv
// tb_sync_payload_capture: directed frame vectors plus hand-written corner sequences for sync_payload_capture
module tb_sync_payload_capture;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    sync_payload_capture_if #(.PAYLOAD_W(16), .CNT_W(8)) bus();
    sync_payload_capture #(.PAYLOAD_W(16), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
    int total = 0;
    int bad = 0;
    logic [11:0] sync_word = 12'hEDB;
    typedef struct {
        logic rst;
        logic [15:0] data;
        logic rdy;
        logic rdy_last;
        logic [15:0] e_pay;
        logic e_valid;
        logic [7:0] e_cnt;
        logic e_ovr;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic pv, pr, prst;
        logic [15:0] pp;
        pv = bus.valid_o;
        pp = bus.payload_o;
        pr = bus.ready_i;
        prst = reset;
        @(posedge clk);
        #1;
        if (pv && !pr && !prst) begin
            chk("hold_valid", bus.valid_o, 1);
            chk("hold_payload", bus.payload_o, pp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.x_i = 1'b0;
        bus.det_i = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic send_sync(input logic rdy);
        for (int i = 11; i >= 0; i--) begin
            bus.x_i = sync_word[i];
            bus.det_i = 1'b0;
            bus.ready_i = rdy;
            tick();
        end
    endtask

    task automatic send_payload(input logic [15:0] d, input int first, input int last,
                                input logic rdy, input logic rdy_last, input int extra);
        for (int i = first; i <= last; i++) begin
            bus.x_i = d[15-i];
            bus.det_i = (i == 0) || (i == extra);
            bus.ready_i = (i == 15) ? rdy_last : rdy;
            tick();
        end
        bus.det_i = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 16'h1234, 1'b0, 1'b0, 16'h1234, 1'b1, 8'd1, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 1'b0, 1'b0, 16'h1234, 1'b1, 8'd1, 1'b1};
        vecs[2] = '{1'b1, 16'h1111, 1'b0, 1'b0, 16'h1111, 1'b1, 8'd1, 1'b0};
        vecs[3] = '{1'b0, 16'h5A5A, 1'b0, 1'b1, 16'h5A5A, 1'b1, 8'd2, 1'b0};
        vecs[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 8'd3, 1'b0};
        vecs[5] = '{1'b0, 16'h8001, 1'b0, 1'b1, 16'h8001, 1'b1, 8'd4, 1'b0};
        bus.x_i = 1'b0;
        bus.det_i = 1'b0;
        bus.ready_i = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_payload", bus.payload_o, 0);
        chk("rst_valid", bus.valid_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_cnt", bus.frame_cnt_o, 0);
        chk("rst_ovr", bus.overrun_o, 0);
        send_sync(1'b1);
        send_payload(16'hA5C3, 0, 0, 1'b1, 1'b1, -1);
        chk("t1_busy_rise", bus.busy_o, 1);
        send_payload(16'hA5C3, 1, 14, 1'b1, 1'b1, -1);
        chk("t1_valid_early", bus.valid_o, 0);
        chk("t1_busy_mid", bus.busy_o, 1);
        send_payload(16'hA5C3, 15, 15, 1'b1, 1'b1, -1);
        chk("t1_valid", bus.valid_o, 1);
        chk("t1_payload", bus.payload_o, 16'hA5C3);
        chk("t1_cnt", bus.frame_cnt_o, 1);
        chk("t1_busy_fall", bus.busy_o, 0);
        chk("t1_ovr", bus.overrun_o, 0);
        bus.ready_i = 1'b1;
        tick();
        chk("t1_xfer_valid", bus.valid_o, 0);
        chk("t1_xfer_payload", bus.payload_o, 16'hA5C3);
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].rst) do_reset();
            send_sync(vecs[v].rdy);
            send_payload(vecs[v].data, 0, 15, vecs[v].rdy, vecs[v].rdy_last, -1);
            chk($sformatf("vec%0d_payload", v), bus.payload_o, vecs[v].e_pay);
            chk($sformatf("vec%0d_valid", v), bus.valid_o, vecs[v].e_valid);
            chk($sformatf("vec%0d_cnt", v), bus.frame_cnt_o, vecs[v].e_cnt);
            chk($sformatf("vec%0d_ovr", v), bus.overrun_o, vecs[v].e_ovr);
        end
        do_reset();
        send_sync(1'b1);
        send_payload(16'h0F0F, 0, 15, 1'b1, 1'b1, 5);
        chk("repulse_payload", bus.payload_o, 16'h0F0F);
        chk("repulse_valid", bus.valid_o, 1);
        chk("repulse_cnt", bus.frame_cnt_o, 1);
        chk("repulse_busy", bus.busy_o, 0);
        do_reset();
        send_sync(1'b1);
        send_payload(16'h1234, 0, 7, 1'b1, 1'b1, -1);
        chk("midrst_busy_before", bus.busy_o, 1);
        reset = 1'b1;
        bus.det_i = 1'b1;
        bus.x_i = 1'b1;
        tick();
        reset = 1'b0;
        bus.det_i = 1'b0;
        chk("midrst_payload", bus.payload_o, 0);
        chk("midrst_valid", bus.valid_o, 0);
        chk("midrst_busy", bus.busy_o, 0);
        chk("midrst_cnt", bus.frame_cnt_o, 0);
        chk("midrst_ovr", bus.overrun_o, 0);
        send_payload(16'h1234, 8, 15, 1'b1, 1'b1, -1);
        chk("midrst_tail_valid", bus.valid_o, 0);
        chk("midrst_tail_busy", bus.busy_o, 0);
        send_sync(1'b1);
        send_payload(16'hBEEF, 0, 15, 1'b1, 1'b1, -1);
        chk("beef_payload", bus.payload_o, 16'hBEEF);
        chk("beef_valid", bus.valid_o, 1);
        chk("beef_cnt", bus.frame_cnt_o, 1);
        do_reset();
        for (int f = 0; f < 256; f++) begin
            send_payload(16'(f * 257), 0, 15, 1'b1, 1'b1, -1);
            if (f == 254) chk("wrap_cnt_255", bus.frame_cnt_o, 8'd255);
        end
        chk("wrap_cnt_0", bus.frame_cnt_o, 0);
        chk("wrap_ovr", bus.overrun_o, 0);
        chk("wrap_valid", bus.valid_o, 1);
        chk("wrap_payload", bus.payload_o, 16'hFFFF);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
